// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, NOP encoding and fetch-queue entry type for the fetch stage.
package fetch_unit_pkg;
    localparam int DATAWIDTH = 32;
    localparam logic [DATAWIDTH-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [DATAWIDTH-1:0] pc;
        logic [DATAWIDTH-1:0] inst;
    } fq_entry_t;

    function automatic logic [DATAWIDTH-1:0] word_align(input logic [DATAWIDTH-1:0] a);
        return {a[DATAWIDTH-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus between fetch stage and memory.
interface fetch_unit_if;
    import fetch_unit_pkg::*;
    logic                 imem_req_valid;
    logic                 imem_req_ready;
    logic [DATAWIDTH-1:0] imem_req_addr;
    logic                 imem_resp_valid;
    logic [DATAWIDTH-1:0] imem_resp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data
    );
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data
    );
endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small synchronous FIFO with push/pop/flush and occupancy count.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;

    assign dout = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction fetcher; issues in-order imem requests under a credit
// limit, queues returned words and presents one {inst, pc} per cycle to IF/ID.
module fetch_unit import fetch_unit_pkg::*; #(
    parameter logic [DATAWIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int                   FQ_DEPTH = 4,
    parameter int                   MAX_OUT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [DATAWIDTH-1:0] redirect_pc,
    fetch_unit_if.master         imem,
    output logic [DATAWIDTH-1:0] inst,
    output logic [DATAWIDTH-1:0] pc,
    output logic                 inst_valid
);
    localparam int QCW = $clog2(FQ_DEPTH + 1);
    localparam int OCW = $clog2(MAX_OUT + 1);

    logic [DATAWIDTH-1:0] fetch_pc, out_pc;
    logic [QCW-1:0]       count;
    logic [OCW-1:0]       out_cnt, drop_cnt;
    fq_entry_t            head;
    logic                 resp, accept, q_push, q_pop;

    // Credits cover both in-flight and queued words so the queue can never overflow.
    assign imem.imem_req_valid = !redirect && int'(out_cnt) < MAX_OUT
                                 && int'(out_cnt) + int'(count) < FQ_DEPTH;
    assign imem.imem_req_addr  = fetch_pc;
    assign accept     = imem.imem_req_valid && imem.imem_req_ready;
    assign resp       = imem.imem_resp_valid && out_cnt != '0;
    assign q_push     = resp && drop_cnt == '0 && !redirect;
    assign q_pop      = count != '0 && !stall && !redirect;
    assign inst_valid = count != '0;
    assign inst       = inst_valid ? head.inst : NOP;
    assign pc         = inst_valid ? head.pc : fetch_pc;

    fetch_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(FQ_DEPTH)) u_fq (
        .clk(clk), .rst(rst), .flush(redirect),
        .push(q_push), .din({out_pc, imem.imem_resp_data}),
        .pop(q_pop), .dout(head), .count(count)
    );

    // Addresses of outstanding requests; responses return in order so the head matches.
    fetch_fifo #(.WIDTH(DATAWIDTH), .DEPTH(MAX_OUT)) u_pcf (
        .clk(clk), .rst(rst), .flush(1'b0),
        .push(accept), .din(fetch_pc),
        .pop(resp), .dout(out_pc), .count(out_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect) begin
            fetch_pc <= word_align(redirect_pc);
            drop_cnt <= out_cnt - OCW'(resp);
        end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (resp && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (!rst && imem.imem_resp_valid) assert (out_cnt != '0);
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32IMV pipeline. It owns the program counter, issues in-order requests to instruction memory over a valid/ready request and valid response interface, and buffers returned words in a small fetch queue. Each cycle it presents one `{inst, pc}` pair to the IF/ID pipeline register. It honours the hazard-unit stall and absorbs branch/jump redirects from EX by flushing queued and in-flight fetches.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset.
- `FQ_DEPTH`, default 4: fetch-queue entries; power of two, ≥2.
- `MAX_OUT`, default 2: maximum outstanding memory requests.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: IF/ID holds this cycle; the head entry is not consumed.
- `redirect` in 1: branch/jump taken, resolved in EX.
- `redirect_pc` in `datawidth`: new fetch PC; bits [1:0] ignored and treated as 0.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out `datawidth`: word-aligned fetch address.
- `imem_resp_valid` in 1: response word present; responses return in order, latency ≥1 cycle.
- `imem_resp_data` in `datawidth`: instruction word.
- `inst` out `datawidth`: instruction to IF/ID.
- `pc` out `datawidth`: PC of `inst`.
- `inst_valid` out 1: `inst`/`pc` carry a real fetched instruction; 0 means bubble.

## Operation
- State: `fetch_pc`, fetch queue (`FQ_DEPTH` × {pc, inst}, with rd/wr pointers and count), `out_cnt` (0..MAX_OUT), `drop_cnt` (0..MAX_OUT), and a PC FIFO of depth MAX_OUT holding the addresses of outstanding requests.
- Issue: `imem_req_valid` = !redirect && out_cnt < MAX_OUT && (out_cnt + count) < FQ_DEPTH.
  - `imem_req_addr` = `fetch_pc`.
  - On accept (valid && ready): `fetch_pc` += 4, which wraps modulo 2^32. The address is pushed to the PC FIFO and `out_cnt` increments.
  - The request may be withdrawn without acceptance. Memory keeps no state from unaccepted requests.
- Response: each `imem_resp_valid` pops the PC FIFO and decrements `out_cnt`.
  - If `drop_cnt` > 0, the word is discarded and `drop_cnt` decrements.
  - Otherwise {popped pc, data} is written to the queue tail.
- Output: when count > 0, `inst`/`pc` show the queue head and `inst_valid`=1. When the queue is empty, the outputs are `inst`=32'h0000_0013 (NOP), `pc`=`fetch_pc`, and `inst_valid`=0.
- Pop: the head is consumed when count > 0 && !stall && !redirect.
- Redirect (has priority over stall, response and pop):
  - `fetch_pc` ← {redirect_pc[31:2], 2'b00}.
  - Queue is flushed (count=0, pointers reset).
  - `drop_cnt` ← out_cnt − imem_resp_valid. A response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle.
  - The outputs in the redirect cycle still show pre-flush state. IF/ID is expected to be flushed externally in that cycle.
- Simultaneous response, accepted request and pop in one cycle: all three take effect. Count and out_cnt update by their net deltas.
- A response while out_cnt=0 is a protocol error. It is ignored. In simulation it triggers an assertion.

## Timing
- Reset values: `fetch_pc`=RESET_PC, count=0, out_cnt=0, drop_cnt=0. This gives `inst`=NOP, `pc`=RESET_PC, `inst_valid`=0, and `imem_req_valid`=1 in the first cycle after reset deasserts.
- Reset mid-operation discards all queued and in-flight state. Late responses after reset are ignored because out_cnt=0.
- Queue write to output: a word returned in cycle n is visible on `inst` in cycle n+1. There is no bypass.
- Best-case fetch latency from request accept to `inst_valid` = memory latency + 1.
- Throughput: with 1-cycle memory and no stall, steady state is 1 instruction per cycle.
- The first valid instruction after a redirect in cycle r appears no earlier than r+3: request in r+1, response in r+2, output in r+3.
- Stall freezes the outputs and the queue head. Fetch continues until the credit limit is reached.

## Structure
- `datawidth` and the NOP encoding (32'h0000_0013) come from the shared defines header. The NOP constant is added there if missing.
- One sub-module, `fetch_fifo`: parameterised sync FIFO with push/pop/flush/count. It is instantiated twice: once as the fetch queue (width 2·datawidth) and once as the outstanding-PC FIFO (width datawidth, depth MAX_OUT).

## Test plan
- Reset, then 1-cycle memory returning data=addr, no stall: `inst_valid` first rises 2 cycles after reset release with pc=0. Then pc=0,4,8,… one per cycle.
- Stall held 5 cycles in steady state: `inst`/`pc` frozen. Requests stop after out_cnt+count reaches 4. On release, the stream resumes with no PC skipped or duplicated.
- Redirect to 32'h0000_0103 with 2 requests outstanding and 2 queued: both late responses are dropped. The next valid output has pc=32'h0000_0100.
- Random `imem_req_ready` and 1–4 cycle response latency over 1000 fetches against a scoreboard: in-order, gap-free PCs. out_cnt never exceeds 2 and count never exceeds 4.
- `fetch_pc`=32'hFFFF_FFFC: the next request address wraps to 32'h0000_0000.
- Redirect and stall in the same cycle that a response arrives: the response is discarded, the redirect is taken, and `drop_cnt` equals out_cnt−1.
